// File: rtl/adat_pkg.sv
// adat_pkg: shared state encoding, frame-layout constants and default
// parameters for the ADAT frame deframer.
package adat_pkg;

    typedef enum logic [2:0] {
        HUNT,
        USER,
        SEP,
        NIBBLE,
        GAP
    } state_t;

    localparam int unsigned NIBBLE_BITS      = 4;
    localparam int unsigned USER_BITS        = 4;
    localparam int unsigned ZERO_CNT_W       = 4;

    localparam int unsigned DEF_SYNC_ZEROS   = 10;
    localparam int unsigned DEF_CHANNELS     = 8;
    localparam int unsigned DEF_SAMPLE_WIDTH = 24;

endpackage

// File: rtl/adat_sync_detector.sv
// adat_sync_detector: saturating count of consecutive 0 bits plus the
// "enough zeros, then a 1" sync qualifier used while hunting and in the gap.
module adat_sync_detector
    import adat_pkg::*;
#(
    parameter int unsigned SYNC_ZEROS = DEF_SYNC_ZEROS
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic data,
    input  logic clear,
    input  logic preset,
    output logic sync_hit,
    output logic run_done
);

    logic [ZERO_CNT_W-1:0] zero_cnt;

    assign sync_hit = data && (zero_cnt >= ZERO_CNT_W'(SYNC_ZEROS));
    // True when the current 0 bit is the one that completes the sync run.
    assign run_done = !data && (zero_cnt == ZERO_CNT_W'(SYNC_ZEROS - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            zero_cnt <= '0;
        end else if (preset) begin
            zero_cnt <= ZERO_CNT_W'(1);
        end else if (step) begin
            if (data)
                zero_cnt <= '0;
            else if (zero_cnt != '1)
                zero_cnt <= zero_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adat_frame_deframer.sv
// adat_frame_deframer: parses the decoded ADAT bit stream into user bits and
// serialised per-channel samples, and tracks frame lock.
module adat_frame_deframer
    import adat_pkg::*;
#(
    parameter int unsigned SYNC_ZEROS   = DEF_SYNC_ZEROS,
    parameter int unsigned CHANNELS     = DEF_CHANNELS,
    parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
) (
    input  logic                        clk_x4_i,
    input  logic                        rst_i,
    input  logic                        tick_ni,
    input  logic                        data_i,
    input  logic                        valid_i,
    input  logic                        sync_i,
    output logic [SAMPLE_WIDTH-1:0]     sample_o,
    output logic [$clog2(CHANNELS)-1:0] channel_o,
    output logic                        sample_valid_o,
    output logic [3:0]                  user_o,
    output logic                        frame_done_o,
    output logic                        frame_error_o,
    output logic                        locked_o
);

    localparam int unsigned GROUPS = SAMPLE_WIDTH / NIBBLE_BITS;
    localparam int unsigned CH_W   = $clog2(CHANNELS);
    localparam int unsigned GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned NIB_W  = $clog2(NIBBLE_BITS);
    localparam int unsigned USR_W  = $clog2(USER_BITS);

    state_t                  state_q, state_d;
    logic                    step, sync_q;
    logic                    sync_hit, run_done;
    logic                    cnt_step, cnt_clear, cnt_one;
    logic                    start, user_load, emit, done, err;
    logic [USR_W-1:0]        user_cnt;
    logic [USER_BITS-1:0]    user_sr;
    logic [NIB_W-1:0]        nib_cnt;
    logic [GRP_W-1:0]        grp_cnt;
    logic [CH_W-1:0]         chan;
    logic [SAMPLE_WIDTH-1:0] sample_sr, sample_next;

    assign step        = !tick_ni && valid_i && sync_i;
    assign sample_next = {sample_sr[SAMPLE_WIDTH-2:0], data_i};

    adat_sync_detector #(.SYNC_ZEROS(SYNC_ZEROS)) u_sync (
        .clk      (clk_x4_i),
        .rst      (rst_i),
        .step     (cnt_step),
        .data     (data_i),
        .clear    (cnt_clear),
        .preset   (cnt_one),
        .sync_hit (sync_hit),
        .run_done (run_done)
    );

    always_comb begin
        state_d   = state_q;
        cnt_step  = 1'b0;
        cnt_clear = 1'b0;
        cnt_one   = 1'b0;
        start     = 1'b0;
        user_load = 1'b0;
        emit      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        // Loss of decoder lock overrides everything; only its falling edge errors.
        if (!sync_i) begin
            state_d   = HUNT;
            cnt_clear = 1'b1;
            err       = sync_q && (state_q != HUNT);
        end else if (step) begin
            case (state_q)
                HUNT: begin
                    cnt_step = 1'b1;
                    if (sync_hit) begin
                        state_d = USER;
                        start   = 1'b1;
                    end
                end
                USER: begin
                    if (user_cnt == USR_W'(USER_BITS - 1)) begin
                        state_d   = SEP;
                        user_load = 1'b1;
                    end
                end
                SEP: begin
                    if (data_i) begin
                        state_d = NIBBLE;
                    end else begin
                        state_d = HUNT;
                        err     = 1'b1;
                        cnt_one = 1'b1;
                    end
                end
                NIBBLE: begin
                    if (nib_cnt == NIB_W'(NIBBLE_BITS - 1)) begin
                        state_d = SEP;
                        if (grp_cnt == GRP_W'(GROUPS - 1)) begin
                            emit = 1'b1;
                            if (chan == CH_W'(CHANNELS - 1))
                                state_d = GAP;
                        end
                    end
                end
                GAP: begin
                    cnt_step = 1'b1;
                    if (data_i) begin
                        if (sync_hit) begin
                            state_d = USER;
                            start   = 1'b1;
                        end else begin
                            state_d = HUNT;
                            err     = 1'b1;
                        end
                    end else if (run_done) begin
                        done = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_x4_i) begin
        if (rst_i) begin
            state_q        <= HUNT;
            sync_q         <= 1'b0;
            user_cnt       <= '0;
            user_sr        <= '0;
            nib_cnt        <= '0;
            grp_cnt        <= '0;
            chan           <= '0;
            sample_sr      <= '0;
            sample_o       <= '0;
            channel_o      <= '0;
            sample_valid_o <= 1'b0;
            user_o         <= '0;
            frame_done_o   <= 1'b0;
            frame_error_o  <= 1'b0;
            locked_o       <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_i;
            sample_valid_o <= emit;
            frame_done_o   <= done;
            frame_error_o  <= err;
            if (err || !sync_i)
                locked_o <= 1'b0;
            else if (done)
                locked_o <= 1'b1;
            if (start)
                user_cnt <= '0;
            if (step && state_q == USER) begin
                user_cnt <= user_cnt + 1'b1;
                user_sr  <= {user_sr[USER_BITS-2:0], data_i};
            end
            if (user_load) begin
                user_o  <= {user_sr[USER_BITS-2:0], data_i};
                nib_cnt <= '0;
                grp_cnt <= '0;
                chan    <= '0;
            end
            if (step && state_q == NIBBLE) begin
                sample_sr <= sample_next;
                nib_cnt   <= nib_cnt + 1'b1;
                if (nib_cnt == NIB_W'(NIBBLE_BITS - 1))
                    grp_cnt <= (grp_cnt == GRP_W'(GROUPS - 1)) ? '0 : grp_cnt + 1'b1;
            end
            if (emit) begin
                sample_o  <= sample_next;
                channel_o <= chan;
                chan      <= chan + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adat_frame_deframer.sv
// tb_adat_frame_deframer: table-driven frame vectors plus hand-written
// latency, sync-dropout and mid-frame reset sequences.
module tb_adat_frame_deframer;

    localparam int unsigned CH = 8;
    localparam int unsigned SW = 24;

    logic          clk = 1'b0;
    logic          rst_i, tick_ni, data_i, valid_i, sync_i;
    logic [SW-1:0] sample_o;
    logic [2:0]    channel_o;
    logic          sample_valid_o;
    logic [3:0]    user_o;
    logic          frame_done_o, frame_error_o, locked_o;

    always #5 clk = ~clk;

    adat_frame_deframer #(.SYNC_ZEROS(10), .CHANNELS(CH), .SAMPLE_WIDTH(SW)) dut (
        .clk_x4_i       (clk),
        .rst_i          (rst_i),
        .tick_ni        (tick_ni),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .sync_i         (sync_i),
        .sample_o       (sample_o),
        .channel_o      (channel_o),
        .sample_valid_o (sample_valid_o),
        .user_o         (user_o),
        .frame_done_o   (frame_done_o),
        .frame_error_o  (frame_error_o),
        .locked_o       (locked_o)
    );

    int unsigned   errors = 0;
    int unsigned   checks = 0;
    logic [SW-1:0] mon_val[$];
    logic [2:0]    mon_ch[$];
    int unsigned   mon_done = 0, mon_err = 0, overlap = 0;
    logic          bits[$];

    always @(negedge clk) begin
        if (sample_valid_o) begin
            mon_val.push_back(sample_o);
            mon_ch.push_back(channel_o);
        end
        if (frame_done_o) mon_done++;
        if (frame_error_o) mon_err++;
        if (sample_valid_o && frame_error_o) overlap++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] sval(input int c, input logic [SW-1:0] mul, input logic [SW-1:0] add);
        logic [SW-1:0] r;
        r = add;
        for (int i = 0; i < c; i++) r = r + mul;
        return r;
    endfunction

    task automatic push_zeros(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) bits.push_back(1'b0);
    endtask

    task automatic push_frame(input logic [3:0] user, input logic [SW-1:0] mul, input logic [SW-1:0] add,
                              input int bad_ch, input int bad_grp);
        logic [SW-1:0] s;
        bits.push_back(1'b1);
        for (int i = 3; i >= 0; i--) bits.push_back(user[i]);
        for (int c = 0; c < CH; c++) begin
            s = sval(c, mul, add);
            for (int g = 0; g < SW / 4; g++) begin
                bits.push_back(!(c == bad_ch && g == bad_grp));
                for (int k = 0; k < 4; k++) bits.push_back(s[SW-1-4*g-k]);
            end
        end
    endtask

    task automatic drive_bit(input logic b, input int unsigned idle);
        @(posedge clk); #1;
        tick_ni = 1'b0; valid_i = 1'b1; data_i = b;
        for (int unsigned i = 0; i < idle; i++) begin
            @(posedge clk); #1;
            tick_ni = !i[0]; valid_i = !i[0]; data_i = ~b;
        end
    endtask

    task automatic send(input int unsigned n, input int unsigned idle);
        for (int unsigned i = 0; i < n && bits.size() > 0; i++) drive_bit(bits.pop_front(), idle);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        tick_ni = 1'b1; valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1; tick_ni = 1'b1; valid_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sample"}, 32'(sample_o), 0);
        check({tag, "_channel"}, 32'(channel_o), 0);
        check({tag, "_valid"}, 32'(sample_valid_o), 0);
        check({tag, "_user"}, 32'(user_o), 0);
        check({tag, "_done"}, 32'(frame_done_o), 0);
        check({tag, "_error"}, 32'(frame_error_o), 0);
        check({tag, "_locked"}, 32'(locked_o), 0);
    endtask

    task automatic check_frame(input string tag, input int unsigned base, input logic [SW-1:0] mul,
                               input logic [SW-1:0] add);
        for (int unsigned i = 0; i < CH; i++) begin
            if (base + i < mon_val.size()) begin
                check($sformatf("%s_ch%0d_idx", tag, i), 32'(mon_ch[base+i]), i);
                check($sformatf("%s_ch%0d_val", tag, i), 32'(mon_val[base+i]), 32'(sval(int'(i), mul, add)));
            end
        end
    endtask

    typedef struct {
        int unsigned   pre;
        logic [3:0]    user;
        logic [SW-1:0] mul;
        logic [SW-1:0] add;
        int            bad_ch;
        int            bad_grp;
        int unsigned   idle;
        int unsigned   f1_samples;
        int unsigned   exp_done;
        int unsigned   exp_err;
    } vec_t;

    vec_t        vecs[5];
    int unsigned base, d0, e0, n, fi;

    initial begin
        // ideal stream, bad separator, short sync, tick gating, long saturating gap
        vecs[0] = '{10, 4'b1010, 24'h111111, 24'h000000, -1, -1, 0, 8, 2, 0};
        vecs[1] = '{10, 4'b0110, 24'h111111, 24'h000000,  3,  2, 0, 3, 1, 1};
        vecs[2] = '{ 9, 4'b1100, 24'h111111, 24'h000000, -1, -1, 0, 0, 1, 0};
        vecs[3] = '{12, 4'b0011, 24'h0A0B0C, 24'h123456, -1, -1, 3, 8, 2, 0};
        vecs[4] = '{20, 4'b1001, 24'h200001, 24'h00F00F, -1, -1, 0, 8, 2, 0};

        rst_i = 1'b1; tick_ni = 1'b1; valid_i = 1'b0; data_i = 1'b0; sync_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        #1 rst_i = 1'b0;

        for (int v = 0; v < 5; v++) begin
            do_reset();
            base = mon_val.size(); d0 = mon_done; e0 = mon_err;
            bits.delete();
            push_zeros(vecs[v].pre);
            push_frame(vecs[v].user, vecs[v].mul, vecs[v].add, vecs[v].bad_ch, vecs[v].bad_grp);
            push_zeros(10);
            push_frame(vecs[v].user, vecs[v].mul, vecs[v].add, -1, -1);
            push_zeros(10);
            send(bits.size(), vecs[v].idle);
            go_idle();
            repeat (2) @(negedge clk);
            n = vecs[v].f1_samples + CH;
            check($sformatf("v%0d_count", v), mon_val.size() - base, n);
            for (int unsigned i = 0; i < n && base + i < mon_val.size(); i++) begin
                fi = (i < vecs[v].f1_samples) ? i : i - vecs[v].f1_samples;
                check($sformatf("v%0d_s%0d_ch", v, i), 32'(mon_ch[base+i]), fi);
                check($sformatf("v%0d_s%0d_val", v, i), 32'(mon_val[base+i]),
                      32'(sval(int'(fi), vecs[v].mul, vecs[v].add)));
            end
            check($sformatf("v%0d_done", v), mon_done - d0, vecs[v].exp_done);
            check($sformatf("v%0d_err", v), mon_err - e0, vecs[v].exp_err);
            check($sformatf("v%0d_locked", v), 32'(locked_o), 1);
            check($sformatf("v%0d_user", v), 32'(user_o), 32'(vecs[v].user));
        end

        // Latency: strobe exactly one cycle after the LSB bit event, one cycle wide.
        do_reset();
        bits.delete();
        push_zeros(10);
        push_frame(4'b0101, 24'h010101, 24'hABCDEF, -1, -1);
        send(45, 0);
        @(negedge clk);
        check("lat_early", 32'(sample_valid_o), 0);
        go_idle();
        @(negedge clk);
        check("lat_valid", 32'(sample_valid_o), 1);
        check("lat_sample", 32'(sample_o), 32'h00ABCDEF);
        check("lat_channel", 32'(channel_o), 0);
        check("lat_user", 32'(user_o), 32'h5);
        @(negedge clk);
        check("lat_width", 32'(sample_valid_o), 0);

        // sync_i dropout during channel 5 after a locked frame.
        do_reset();
        base = mon_val.size(); d0 = mon_done; e0 = mon_err;
        bits.delete();
        push_zeros(10);
        push_frame(4'b1110, 24'h111111, 24'h000000, -1, -1);
        push_zeros(10);
        send(bits.size(), 0);
        go_idle();
        @(negedge clk);
        check("drop_locked_before", 32'(locked_o), 1);
        push_frame(4'b1110, 24'h111111, 24'h000000, -1, -1);
        send(165, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            sync_i = 1'b0; tick_ni = 1'b0; valid_i = 1'b1; data_i = 1'($urandom);
        end
        @(posedge clk); #1;
        sync_i = 1'b1; tick_ni = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        check("drop_err", mon_err - e0, 1);
        check("drop_locked_after", 32'(locked_o), 0);
        check("drop_partial", mon_val.size() - base, 13);
        bits.delete();
        push_zeros(10);
        push_frame(4'b0001, 24'h0F0F0F, 24'h102030, -1, -1);
        push_zeros(10);
        send(bits.size(), 0);
        go_idle();
        repeat (2) @(negedge clk);
        check("drop_count", mon_val.size() - base, 21);
        check_frame("drop_rec", base + 13, 24'h0F0F0F, 24'h102030);
        check("drop_err_total", mon_err - e0, 1);
        check("drop_done", mon_done - d0, 2);
        check("drop_relock", 32'(locked_o), 1);

        // Reset pulse in the middle of channel 2.
        do_reset();
        base = mon_val.size(); d0 = mon_done;
        bits.delete();
        push_zeros(10);
        push_frame(4'b1011, 24'h111111, 24'h000000, -1, -1);
        push_zeros(10);
        send(bits.size(), 0);
        push_frame(4'b1011, 24'h111111, 24'h000000, -1, -1);
        send(80, 0);
        check("rst_partial", mon_val.size() - base, 10);
        do_reset();
        @(negedge clk);
        check_zero("midrst");
        base = mon_val.size(); d0 = mon_done;
        send(bits.size(), 0);
        go_idle();
        repeat (2) @(negedge clk);
        check("rst_no_samples", mon_val.size() - base, 0);
        push_zeros(10);
        push_frame(4'b0111, 24'h000111, 24'h0F0000, -1, -1);
        push_zeros(10);
        send(bits.size(), 0);
        go_idle();
        repeat (2) @(negedge clk);
        check("rst_count", mon_val.size() - base, 8);
        check_frame("rst_rec", base, 24'h000111, 24'h0F0000);
        check("rst_done", mon_done - d0, 1);
        check("rst_user", 32'(user_o), 32'h7);

        check("no_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adat_frame_deframer.md
Name: adat_frame_deframer

Overview:
- Consumes the recovered bit stream from nrzi_phase_lock_decoder (data_o, valid_o, sync_o, clk_main_tick_no) and parses ADAT frames.
- Finds the sync gap, checks the separator bits, strips them, and assembles the 4 user bits and 8 × 24-bit channel samples.
- Emits one sample per channel, serialised, with a per-sample strobe.
- Sits between the NRZI decoder and the sample FIFO / USB packetiser.

Parameters:
- SYNC_ZEROS, 10, minimum run of consecutive 0 bits that qualifies as a frame sync.
- CHANNELS, 8, channels per frame.
- SAMPLE_WIDTH, 24, bits per sample; must be a multiple of 4.

Ports:
- clk_x4_i  in  1  4× bit clock, the same clock that drives the decoder.
- rst_i  in  1  synchronous reset, active-high.
- tick_ni  in  1  bit-slot enable, active-low; connects to decoder clk_main_tick_no.
- data_i  in  1  decoded bit; connects to decoder data_o.
- valid_i  in  1  decoded bit is valid; connects to decoder valid_o.
- sync_i  in  1  decoder phase-locked; connects to decoder sync_o.
- sample_o  out  SAMPLE_WIDTH  assembled sample, MSB first on the wire.
- channel_o  out  $clog2(CHANNELS)  channel index of sample_o.
- sample_valid_o  out  1  one-cycle strobe; sample_o and channel_o are valid.
- user_o  out  4  user bits of the current frame, first received bit in user_o[3].
- frame_done_o  out  1  one-cycle strobe after the last channel of an error-free frame.
- frame_error_o  out  1  one-cycle strobe on any framing violation.
- locked_o  out  1  high while frames are parsing without error.

Behaviour:
- Single clock domain: clk_x4_i, with synchronous active-high reset rst_i.
- A bit event is a cycle where tick_ni==0 and valid_i==1. All state advances only on bit events. Other cycles hold state; strobes are forced low.
- Reset state: all outputs 0, state HUNT, all counters 0.
- Frame layout after the sync gap: a 1 bit, then 4 user bits, then CHANNELS×(SAMPLE_WIDTH/4) groups. Each group is a 1 separator bit followed by 4 data bits.
- HUNT:
  - A 0 bit increments zero_cnt; zero_cnt saturates at 15.
  - A 1 bit with zero_cnt>=SYNC_ZEROS goes to USER; user bit counter is cleared.
  - A 1 bit with zero_cnt<SYNC_ZEROS clears zero_cnt and stays in HUNT. This case raises no error.
- USER:
  - Shift 4 bits into a user shift register.
  - After the 4th bit, user_o updates on the following cycle. Go to SEP, with nibble=0 and channel=0.
- SEP:
  - Bit 1 goes to NIBBLE.
  - Bit 0 pulses frame_error_o, clears locked_o, and goes to HUNT with zero_cnt=1 (the offending 0 counts toward the next sync).
- NIBBLE:
  - Shift 4 bits into the sample shift register, MSB first.
  - After the 4th bit, if the sample is incomplete, go to SEP.
  - If the sample is complete: in the next cycle, load sample_o and channel_o, pulse sample_valid_o for 1 cycle, and increment channel.
  - After the last channel, go to GAP.
  - Latency: sample_valid_o is asserted exactly 1 clk_x4_i cycle after the bit event carrying the sample LSB.
- GAP:
  - Count 0 bits exactly as in HUNT.
  - Reaching SYNC_ZEROS zeros pulses frame_done_o, sets locked_o, and stays in GAP.
  - A 1 bit after SYNC_ZEROS or more zeros goes to USER, starting the next frame.
  - A 1 bit before SYNC_ZEROS zeros pulses frame_error_o, clears locked_o, and goes to HUNT with zero_cnt=0.
- sync_i low in any state:
  - Go to HUNT and clear zero_cnt and locked_o.
  - If sync_i falls outside HUNT, pulse frame_error_o once on the falling edge only. No repeated pulses while sync_i stays low.
- rst_i high mid-frame: the reset values apply on the next edge. No partial sample or strobe is emitted.
- A stream that starts mid-frame cannot produce spurious samples before a valid sync gap. Data 0-nibbles cannot fake a sync because separator 1s break every run at ≤4 zeros.
- sample_valid_o and frame_error_o are never asserted in the same cycle.

Decomposition:
- adat_pkg holds:
  - the state enum (HUNT, USER, SEP, NIBBLE, GAP);
  - localparams NIBBLE_BITS=4 and USER_BITS=4;
  - the default SYNC_ZEROS, CHANNELS and SAMPLE_WIDTH.
- One sub-module, adat_sync_detector: the saturating zero-run counter and the ">=SYNC_ZEROS then 1" detector, shared by HUNT and GAP.

Test Plan:
- Ideal stream:
  - Stimulus: 10 zeros; 1; user 1010; channel n carries 0x00_0000 + n×0x111111 with separators.
  - Required: 8 sample_valid_o strobes with channel 0..7 and matching samples; user_o=4'b1010; frame_done_o after the 10th zero of the next gap; locked_o=1.
- Bad separator:
  - Stimulus: force the separator before channel 3 nibble 2 to 0.
  - Required: frame_error_o pulses once; locked_o=0; no further samples; the next clean frame is decoded fully.
- Short sync:
  - Stimulus: 9 zeros then 1, then a full frame body.
  - Required: no samples; the following 10-zero frame decodes.
- Tick gating:
  - Stimulus: the same frame through nrzi_phase_lock_decoder with jitter 2.0.
  - Required: samples match the transmitted values bit-exactly.
- sync_i dropout:
  - Stimulus: sync_i held low for 20 cycles during channel 5.
  - Required: a single frame_error_o; HUNT; recovery on the next valid gap.
- Reset mid-frame:
  - Stimulus: rst_i=1 for 1 cycle during channel 2.
  - Required: all outputs 0 next cycle; no sample_valid_o until a fresh sync.
